vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameters HS_POL 0 and VS_POL 0: sync active level, where 0 means active-low.
REQ-006 SHALL have parameter PIX_DIV, default 2, giving clk_i cycles per pixel (range 1..16).
REQ-007 SHALL have parameter CW, default 11, giving the coordinate width.
REQ-008 clk_i  in  1  sole clock.
REQ-009 rst_i  in  1  reset, asynchronous and active-high.
REQ-010 en_i  in  1  run enable; low freezes all timing state.
REQ-011 pat_sel_i  in  2  test-pattern select.
REQ-012 pix_stb_o  out  1  one-clk pixel strobe.
REQ-013 x_o, y_o  out  CW each  current pixel column and line.
REQ-014 de_o, hs_o, vs_o  out  1 each  data enable, horizontal sync and vertical sync.
REQ-015 sof_o, eol_o  out  1 each  start-of-frame and end-of-line pulses.
REQ-016 red_o, green_o, blue_o  out  4 each  pixel colour.

Function
REQ-017 Divider SHALL count 0..PIX_DIV-1; pix_stb_o SHALL be high while the count is PIX_DIV-1 and en_i is high. With PIX_DIV=1, pix_stb_o SHALL equal en_i.
REQ-018 hcount SHALL advance on each pix_stb_o and wrap to 0 after H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-019 vcount SHALL advance when hcount wraps and wrap to 0 after V_TOTAL-1, where V_TOTAL is the same sum over the V parameters.
REQ-020 Outputs SHALL be registered, with x_o/y_o/de_o/hs_o/vs_o/sof_o/eol_o all reflecting the same (hcount,vcount) and updating one clk after the strobe.
REQ-021 de_o SHALL be high iff hcount<H_ACTIVE and vcount<V_ACTIVE; x_o and y_o SHALL carry the raw counts at all times.
REQ-022 hs_o SHALL be active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vs_o SHALL apply the same rule on vcount.
REQ-023 sof_o SHALL be high for exactly one strobe period at (0,0); eol_o SHALL be high for one strobe period at hcount=H_TOTAL-1.
REQ-024 Deasserting en_i SHALL hold the counters, divider and all outputs; reasserting it SHALL resume without skipping a pixel.
REQ-025 Colour outputs SHALL be 0 whenever de_o is low.

Reset
REQ-026 Asserting rst_i SHALL asynchronously clear the divider, hcount and vcount, even mid-frame.
REQ-027 During reset, x_o, y_o and colour outputs SHALL be 0; de_o, sof_o, eol_o and pix_stb_o SHALL be 0; hs_o and vs_o SHALL be inactive.
REQ-028 The first strobe after release SHALL present (0,0) with sof_o=1.

Configuration
REQ-029 With VGA_TEST_PATTERN_EN defined, pattern logic SHALL drive the colour outputs as follows:
- pat_sel_i=0: black.
- pat_sel_i=1: 8 vertical colour bars, each H_ACTIVE/8 wide; bar index b drives red=b[2], green=b[1], blue=b[0], each replicated to 4'hF.
- pat_sel_i=2: white/black checkerboard, white iff x[5]^y[5].
- pat_sel_i=3: white vertical stripe for 310<x<330, black elsewhere.
REQ-030 Without VGA_TEST_PATTERN_EN, the colour ports SHALL remain present and tied to 0, and pat_sel_i SHALL be ignored.

Structure
REQ-031 Shared package vga_pkg SHALL hold the 640x480@60 timing constants, the pattern-select encodings and the 4-bit colour type.
REQ-032 Pattern logic SHALL be the sub-module vga_pattern (inputs x, y, de, sel; registered rgb output), instantiated only under the macro.
REQ-033 Colour SHALL be delayed to align with de_o, giving zero added skew.

Verification
REQ-034 Defaults, en_i=1, run one frame -> 800x525 strobes, hs low 96 strobes starting at hcount 656, vs low 2 lines starting at vcount 490, 307200 de_o-high strobes.
REQ-035 PIX_DIV=1 with H/V totals set to 10/6 -> sof_o every 60 clks, eol_o every 10 clks.
REQ-036 en_i low for 37 clks at (123,45) -> outputs frozen throughout, next strobe gives (124,45).
REQ-037 rst_i pulsed asynchronously at (700,300) -> outputs zeroed before the next clk edge; after release, first strobe gives (0,0) with sof_o=1.
REQ-038 HS_POL=1, VS_POL=1 -> sync pulses inverted, timing identical to REQ-034.
REQ-039 Macro defined, pat_sel_i=1, x=85 -> rgb=0,0,F (bar 1); during blanking -> rgb=0; macro undefined -> rgb=0 always.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pattern encodings and colour type
package vga_pkg;

  // 640x480@60 reference timing (pixels / lines)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_PIX_DIV  = 2;
  localparam int VGA_CW       = 11;

  // Centre stripe bounds (exclusive on both sides)
  localparam int STRIPE_LO    = 310;
  localparam int STRIPE_HI    = 330;

  typedef logic [3:0] colour_t;

  localparam colour_t COLOUR_OFF  = 4'h0;
  localparam colour_t COLOUR_FULL = 4'hF;

  typedef enum logic [1:0] {
    PAT_BLACK   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_STRIPE  = 2'd3
  } pat_sel_e;

  // Pin level for a sync signal: pol=0 means the pulse drives the pin low
  function automatic logic sync_level(input logic active, input int pol);
    return (active == (pol != 0));
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// rtl/vga_pattern.sv - test-pattern colour generator, registered on the pixel strobe
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int CW       = VGA_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stb_i,
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  logic          de_i,
  input  logic [1:0]    sel_i,
  output logic [3:0]    red_o,
  output logic [3:0]    green_o,
  output logic [3:0]    blue_o
);

  // Width of one of the eight colour bars; never zero for tiny test rasters
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CW-1:0] STRIPE_LO_C = CW'(STRIPE_LO);
  localparam logic [CW-1:0] STRIPE_HI_C = CW'(STRIPE_HI);

  logic [2:0] bar;
  logic       checker_white;
  logic       stripe_white;
  colour_t    red_d, green_d, blue_d;
  colour_t    red_q, green_q, blue_q;

  // Only y bit 5 matters for the checkerboard; the rest are consumed here
  logic unused_y;
  assign unused_y = ^y_i;

  // Bar index from threshold compares rather than a divider
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_i >= CW'(i * BAR_W)) bar = 3'(i);
    end
  end

  assign checker_white = x_i[5] ^ y_i[5];
  assign stripe_white  = (x_i > STRIPE_LO_C) && (x_i < STRIPE_HI_C);

  // Select the pattern colour; blanking forces black
  always_comb begin
    red_d   = COLOUR_OFF;
    green_d = COLOUR_OFF;
    blue_d  = COLOUR_OFF;
    if (de_i) begin
      case (pat_sel_e'(sel_i))
        PAT_BARS: begin
          red_d   = {4{bar[2]}};
          green_d = {4{bar[1]}};
          blue_d  = {4{bar[0]}};
        end
        PAT_CHECKER: begin
          red_d   = checker_white ? COLOUR_FULL : COLOUR_OFF;
          green_d = checker_white ? COLOUR_FULL : COLOUR_OFF;
          blue_d  = checker_white ? COLOUR_FULL : COLOUR_OFF;
        end
        PAT_STRIPE: begin
          red_d   = stripe_white ? COLOUR_FULL : COLOUR_OFF;
          green_d = stripe_white ? COLOUR_FULL : COLOUR_OFF;
          blue_d  = stripe_white ? COLOUR_FULL : COLOUR_OFF;
        end
        default: begin
          red_d   = COLOUR_OFF;
          green_d = COLOUR_OFF;
          blue_d  = COLOUR_OFF;
        end
      endcase
    end
  end

  // Colour register loads on the same strobe as the timing outputs, so it lines up with de
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_q   <= COLOUR_OFF;
      green_q <= COLOUR_OFF;
      blue_q  <= COLOUR_OFF;
    end else if (stb_i) begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TEST_PATTERN_EN enables vga_pattern colour
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int CW       = VGA_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [1:0]    pat_sel_i,
  output logic          pix_stb_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic [3:0]    red_o,
  output logic [3:0]    green_o,
  output logic [3:0]    blue_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_IDLE = sync_level(1'b0, HS_POL);
  localparam logic VS_IDLE = sync_level(1'b0, VS_POL);

  // Divider is 4 bits wide: PIX_DIV is limited to 1..16
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          stb;

  logic          de_d, hs_d, vs_d, sof_d, eol_d;
  logic [CW-1:0] x_q, y_q;
  logic          de_q, hs_q, vs_q, sof_q, eol_q;

  // Strobe is masked by reset so it reads 0 while rst_i is held, even with PIX_DIV=1
  assign stb       = en_i && !rst_i && (div_q == DIV_LAST);
  assign pix_stb_o = stb;

  // Divider advances only while enabled, so a pause resumes mid-pixel where it stopped
  always_comb begin
    div_d = div_q;
    if (en_i) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
  end

  // Raster counters step once per strobe; vcount steps when hcount wraps
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (stb) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
  end

  // Timing state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= 4'd0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Decode the current position; the result is registered below on the strobe
  always_comb begin
    de_d  = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
    hs_d  = sync_level((hcount_q >= HS_START) && (hcount_q < HS_END), HS_POL);
    vs_d  = sync_level((vcount_q >= VS_START) && (vcount_q < VS_END), VS_POL);
    sof_d = (hcount_q == '0) && (vcount_q == '0);
    eol_d = (hcount_q == H_LAST);
  end

  // Output register: every signal describes the same pixel, one clk after its strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= HS_IDLE;
      vs_q  <= VS_IDLE;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else if (stb) begin
      x_q   <= hcount_q;
      y_q   <= vcount_q;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign de_o  = de_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign sof_o = sof_q;
  assign eol_o = eol_q;

`ifdef VGA_TEST_PATTERN_EN
  // Pattern sees the same counters and strobe as the output register, so colour has no skew vs de_o
  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stb_i   (stb),
    .x_i     (hcount_q),
    .y_i     (vcount_q),
    .de_i    (de_d),
    .sel_i   (pat_sel_i),
    .red_o   (red_o),
    .green_o (green_o),
    .blue_o  (blue_o)
  );
`else
  // No pattern logic: colour ports stay black and the select input is ignored
  logic unused_pat_sel;
  assign unused_pat_sel = ^pat_sel_i;
  assign red_o   = COLOUR_OFF;
  assign green_o = COLOUR_OFF;
  assign blue_o  = COLOUR_OFF;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_ON = 1'b1;
`else
  localparam bit PAT_ON = 1'b0;
`endif

  logic clk, rst, en_a, en_b, en_c;
  logic [1:0] pat_a, pat_b, pat_c;

  logic stb_a, stb_b, stb_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic de_a, hs_a, vs_a, sof_a, eol_a;
  logic de_b, hs_b, vs_b, sof_b, eol_b;
  logic de_c, hs_c, vs_c, sof_c, eol_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic [11:0] rgb_a, rgb_b;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  int n_assert, n_fail;
  int nf, nt, w, k;
  int de_cnt, hs_cnt, vs_cnt, sof_cnt, eol_cnt, first_hs, first_vs;
  int seq_bad, eol_bad, frz_bad, last_x, last_y;
  int sof_t0, sof_t1, eol_t0, eol_t1;
  logic sa, sb, sc, fa, fb, fc;

  // Small raster: 24 x 12 total, PIX_DIV=2, active-low syncs
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIX_DIV(2), .CW(11)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en_a), .pat_sel_i(pat_a),
    .pix_stb_o(stb_a), .x_o(x_a), .y_o(y_a), .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a),
    .sof_o(sof_a), .eol_o(eol_a), .red_o(r_a), .green_o(g_a), .blue_o(b_a)
  );

  // Default 640x480 timing
  vga_timing_gen dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en_b), .pat_sel_i(pat_b),
    .pix_stb_o(stb_b), .x_o(x_b), .y_o(y_b), .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b),
    .sof_o(sof_b), .eol_o(eol_b), .red_o(r_b), .green_o(g_b), .blue_o(b_b)
  );

  // 10 x 6 total, PIX_DIV=1, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .PIX_DIV(1), .CW(11)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en_c), .pat_sel_i(pat_c),
    .pix_stb_o(stb_c), .x_o(x_c), .y_o(y_c), .de_o(de_c), .hs_o(hs_c), .vs_o(vs_c),
    .sof_o(sof_c), .eol_o(eol_c), .red_o(r_c), .green_o(g_c), .blue_o(b_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pexp(input logic [11:0] v);
    return PAT_ON ? v : 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; f* tells whether the edge just taken was a strobe edge
  task automatic tick();
    sa = stb_a; sb = stb_b; sc = stb_c;
    @(posedge clk); #1;
    fa = sa; fb = sb; fc = sc;
  endtask

  task automatic wait_fresh_a(output int n);
    n = 0;
    do begin
      tick(); n++;
    end while (!fa && n < 64);
    if (!fa) n = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0; en_c = 1'b1;
    pat_a = 2'd1; pat_b = 2'd2; pat_c = 2'd0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    chk("rst_x_a", x_a, 0);
    chk("rst_y_a", y_a, 0);
    chk("rst_de_a", de_a, 0);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_sof_a", sof_a, 0);
    chk("rst_eol_a", eol_a, 0);
    chk("rst_stb_a", stb_a, 0);
    chk("rst_stb_c", stb_c, 0);
    chk("rst_hs_c", hs_c, 0);
    chk("rst_vs_c", vs_c, 0);
    chk("rst_rgb_a", rgb_a, 0);

    @(negedge clk); rst = 1'b0; en_c = 1'b0;

    // One full frame on dut_a
    nf = 0; nt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; sof_cnt = 0; eol_cnt = 0;
    first_hs = -1; first_vs = -1; seq_bad = 0; eol_bad = 0; last_x = -1; last_y = -1;
    while (nf < 288 && nt < 2000) begin
      tick(); nt++;
      if (fa) begin
        if (nf == 0) begin
          chk("a_first_x", x_a, 0);
          chk("a_first_y", y_a, 0);
          chk("a_first_sof", sof_a, 1);
        end
        if (int'(x_a) != nf % 24 || int'(y_a) != nf / 24) seq_bad++;
        de_cnt += int'(de_a);
        sof_cnt += int'(sof_a);
        eol_cnt += int'(eol_a);
        if (eol_a !== (nf % 24 == 23)) eol_bad++;
        if (!hs_a) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = int'(x_a);
        end
        if (!vs_a) begin
          vs_cnt++;
          if (first_vs < 0) first_vs = int'(y_a);
        end
        last_x = int'(x_a); last_y = int'(y_a);
        nf++;
      end
    end
    chk("a_frame_ticks", nt, 576);
    chk("a_seq", seq_bad, 0);
    chk("a_de_cnt", de_cnt, 128);
    chk("a_hs_cnt", hs_cnt, 36);
    chk("a_vs_cnt", vs_cnt, 48);
    chk("a_first_hs_x", first_hs, 18);
    chk("a_first_vs_y", first_vs, 9);
    chk("a_sof_cnt", sof_cnt, 1);
    chk("a_eol_cnt", eol_cnt, 12);
    chk("a_eol_pos", eol_bad, 0);
    chk("a_last_x", last_x, 23);
    chk("a_last_y", last_y, 11);

    // Frame wrap
    wait_fresh_a(w);
    chk("a_wrap_lat", w, 2);
    chk("a_wrap_xy", int'(x_a) * 1000 + int'(y_a), 0);
    chk("a_wrap_sof", sof_a, 1);

    // Freeze at (5,3)
    k = 0;
    do begin
      wait_fresh_a(w); k++;
    end while (!(x_a == 11'd5 && y_a == 11'd3) && k < 400 && w > 0);
    chk("a_reach_5_3", int'(x_a) * 1000 + int'(y_a), 5003);
    en_a = 1'b0; frz_bad = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if (x_a !== 11'd5 || y_a !== 11'd3 || stb_a !== 1'b0 || de_a !== 1'b1 ||
          sof_a !== 1'b0 || eol_a !== 1'b0) frz_bad++;
    end
    chk("a_freeze", frz_bad, 0);
    en_a = 1'b1;
    tick();
    chk("a_resume_hold_x", x_a, 5);
    chk("a_resume_stb", stb_a, 1);
    tick();
    chk("a_resume_x", x_a, 6);
    chk("a_resume_y", y_a, 3);

    // Asynchronous reset mid-frame at (10,5)
    k = 0;
    do begin
      wait_fresh_a(w); k++;
    end while (!(x_a == 11'd10 && y_a == 11'd5) && k < 400 && w > 0);
    chk("a_reach_10_5", int'(x_a) * 1000 + int'(y_a), 10005);
    chk("a_de_pre_rst", de_a, 1);
    chk("a_rgb_pre_rst", rgb_a, pexp(12'hF0F));
    #2 rst = 1'b1;
    #1;
    chk("arst_x", x_a, 0);
    chk("arst_y", y_a, 0);
    chk("arst_de", de_a, 0);
    chk("arst_hs", hs_a, 1);
    chk("arst_vs", vs_a, 1);
    chk("arst_stb", stb_a, 0);
    chk("arst_rgb", rgb_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wait_fresh_a(w);
    chk("a_rst_lat", w, 2);
    chk("a_rst_first_xy", int'(x_a) * 1000 + int'(y_a), 0);
    chk("a_rst_first_sof", sof_a, 1);

    // dut_c: PIX_DIV=1, 10x6 raster, active-high syncs
    en_a = 1'b0; en_c = 1'b1;
    sof_cnt = 0; eol_cnt = 0; sof_t0 = 0; sof_t1 = 0; eol_t0 = 0; eol_t1 = 0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    for (int t = 1; t <= 130; t++) begin
      tick();
      if (sof_c) begin
        if (sof_cnt == 0) sof_t0 = t; else if (sof_cnt == 1) sof_t1 = t;
        sof_cnt++;
      end
      if (eol_c) begin
        if (eol_cnt == 0) eol_t0 = t; else if (eol_cnt == 1) eol_t1 = t;
        eol_cnt++;
      end
      if (t <= 60) begin
        hs_cnt += int'(hs_c);
        vs_cnt += int'(vs_c);
        de_cnt += int'(de_c);
      end
    end
    chk("c_sof_first", sof_t0, 1);
    chk("c_sof_period", sof_t1 - sof_t0, 60);
    chk("c_sof_cnt", sof_cnt, 3);
    chk("c_eol_first", eol_t0, 10);
    chk("c_eol_period", eol_t1 - eol_t0, 10);
    chk("c_eol_cnt", eol_cnt, 13);
    chk("c_hs_high", hs_cnt, 12);
    chk("c_vs_high", vs_cnt, 10);
    chk("c_de_cnt", de_cnt, 8);

    // dut_b: first line of the default raster with pattern probes
    en_c = 1'b0; en_b = 1'b1;
    nf = 0; nt = 0; de_cnt = 0; hs_cnt = 0; first_hs = -1; seq_bad = 0; eol_bad = 0;
    while (nf < 800 && nt < 2000) begin
      tick(); nt++;
      if (fb) begin
        if (int'(x_b) != nf || y_b != 11'd0) seq_bad++;
        de_cnt += int'(de_b);
        if (!hs_b) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = int'(x_b);
        end
        if (eol_b !== (nf == 799)) eol_bad++;
        case (nf)
          40:  chk("b_checker_white", rgb_b, pexp(12'hFFF));
          70:  chk("b_checker_black", rgb_b, pexp(12'h000));
          75:  pat_b = 2'd1;
          85:  chk("b_bar1", rgb_b, pexp(12'h00F));
          170: chk("b_bar2", rgb_b, pexp(12'h0F0));
          200: pat_b = 2'd3;
          310: chk("b_stripe_310", rgb_b, pexp(12'h000));
          311: chk("b_stripe_311", rgb_b, pexp(12'hFFF));
          329: chk("b_stripe_329", rgb_b, pexp(12'hFFF));
          330: chk("b_stripe_330", rgb_b, pexp(12'h000));
          600: pat_b = 2'd2;
          639: chk("b_last_active", rgb_b, pexp(12'hFFF));
          672: chk("b_blank_rgb", rgb_b, 0);
          default: ;
        endcase
        nf++;
      end
    end
    chk("b_line_ticks", nt, 1600);
    chk("b_seq", seq_bad, 0);
    chk("b_de_cnt", de_cnt, 640);
    chk("b_hs_cnt", hs_cnt, 96);
    chk("b_first_hs_x", first_hs, 656);
    chk("b_eol_pos", eol_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
